param_serial_cpu: RTL and testbench
===================================

Name: param_serial_cpu

Overview:
- Parametrised successor to the team's 4-bit multi-cycle accumulator CPU: A/B registers, instruction and operand words fetched one word per cycle over a narrow data_in bus.
- Adds configurable data/address width, carry flag, a prefixed extended-op page (CALL/RET/ADC/SWP/CLC) and a hardware return stack with sticky error flag.
- Sits behind the pin-level wrapper; external program/data memory answers addr_out combinationally.

Parameters:
- DW, 4, data/instruction word width; must be >= 4.
- AW, 6, address width; operand beats NA = ceil(AW/DW), MSB-first, first beat uses its low AW-(NA-1)*DW bits.
- STACK_DEPTH, 4, return-stack entries; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous and active-low.
- data_in  in  DW  opcode / sub-op / operand / load data from memory.
- fast  in  1  1 = skip FETCH cycle between instructions.
- addr_out  out  AW  memory address: tmp in MEM state, else pc.
- data_out  out  DW  store data; 0 when wr_en = 0.
- wr_en  out  1  store strobe, single cycle.
- carry  out  1  carry flag.
- stk_err  out  1  sticky stack overflow/underflow.

Behaviour:
- Reset (rst_n = 0 at posedge): pc, A, B, tmp, carry, stack pointer and stk_err go to 0; state goes to FETCH. wr_en is gated by rst_n, so a reset cycle never writes. Reset mid-instruction aborts it.
- States: FETCH, OP, EXT, ABEAT (beat counter 0..NA-1), MEM.
- FETCH: addr_out = pc; next state OP.
- OP: data_in[3:0] is the opcode; pc <= pc+1.
  - 0-7, ALU on A: 0 NGA A = -A; 1 AND; 2 OR; 3 XOR; 4 SLL; 5 SRL; 6 SRA, all shifting by B[clog2(DW)-1:0]; 7 ADD A = A+B, carry = carry-out. No other op touches carry. Then done.
  - 8: go to EXT.
  - 9-F (BEQ, BLE, JMP, LDA, LDB, STA, STB): go to ABEAT with count 0.
- EXT: data_in[3:0] is the sub-op; pc <= pc+1 unless stated.
  - 0 NOP.
  - 1 RET: if stack non-empty, pop and pc <= top; else pc <= pc+1 and stk_err <= 1.
  - 2 CALL: go to ABEAT.
  - 3 ADC: A = A+B+carry, carry updated.
  - 4 SWP: swap A and B.
  - 5 CLC: carry = 0.
  - 6-F: NOP.
  - All except CALL are then done.
- ABEAT: addr_out = pc; tmp <= {tmp, beat}. pc <= pc+1 on every beat except the last, which resolves as follows, with off = assembled AW-bit value and P = address of the last beat:
  - BEQ: if A == B, pc <= P+off mod 2^AW; else P+1.
  - BLE: unsigned; if A <= B, pc <= P+off; else P+1.
  - JMP: pc <= off.
  - CALL: push P+1; pc <= off. If the stack is full, the push is dropped, stk_err <= 1, and the jump still happens.
  - LDx/STx: pc <= P+1, go to MEM.
  - Branches/JMP/CALL: done.
- MEM: addr_out = tmp.
  - LDA/LDB: A/B <= data_in.
  - STA/STB: wr_en = 1, data_out = A/B for this cycle.
  - Then done.
- Done: next state is OP if fast = 1, else FETCH. fast is sampled at the done edge.
- Stack: LIFO, stack pointer 0..STACK_DEPTH. stk_err is cleared only by reset. Simultaneous push and pop is impossible.
- All arithmetic wraps modulo 2^DW (data) or 2^AW (pc).

Test Plan:
- DW=4, A=9, B=8 via LDA/LDB from 0x30/0x31, then ADD -> A=1, carry=1; then ADC with B=0 -> A=2, carry=0.
- STA to 0x2A with A=5: wr_en high for exactly one cycle, addr_out=0x2A, data_out=5; every other cycle wr_en=0, data_out=0.
- BLE with A=3, B=3, offset 0x04, last operand beat at pc=0x0B -> pc=0x0F. Same with A=4 -> pc=0x0C.
- STACK_DEPTH=2, three nested CALLs then four RETs: stk_err rises at the third CALL; first two RETs return correctly; the underflow RET sets pc to the next instruction.
- fast=1 vs fast=0 on ten ADDs: 10 vs 20 cycles, identical A result.
- rst_n low during the MEM cycle of a store: no wr_en pulse; next cycle addr_out=0, carry=0, stk_err=0, state FETCH.

Source files
------------

// File: rtl/param_serial_cpu.sv
// Multi-cycle accumulator CPU with A/B registers, carry flag, extended-op page and
// a hardware return stack; instructions and operands arrive one word per cycle.
module param_serial_cpu #(
  parameter int DW          = 4,
  parameter int AW          = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          fast,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] data_out,
  output logic          wr_en,
  output logic          carry,
  output logic          stk_err
);
  localparam int NA  = (AW + DW - 1) / DW;
  localparam int BW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int SHW = $clog2(DW);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {S_FETCH, S_OP, S_EXT, S_ABEAT, S_MEM} state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  pc_reg, pc_next;
  logic [DW-1:0]  a_reg, a_next, b_reg, b_next;
  logic [AW-1:0]  tmp_reg, tmp_next;
  logic           carry_reg, carry_next;
  logic [SPW-1:0] sp_reg, sp_next;
  logic           err_reg, err_next;
  logic [3:0]     op_reg, op_next;      // 4'h8 marks a CALL in flight
  logic [BW-1:0]  beat_reg, beat_next;
  logic [AW-1:0]  stack_mem [STACK_DEPTH];

  logic           done, push_ok;
  logic [AW-1:0]  pc_inc, off, stack_top;
  logic [DW:0]    add_sum, adc_sum;
  logic [SHW-1:0] shamt;
  logic [IW-1:0]  top_idx, push_idx;

  assign pc_inc    = pc_reg + AW'(1);
  // Shifting the current beat in and truncating keeps only the live operand bits.
  assign off       = AW'({tmp_reg, data_in});
  assign add_sum   = {1'b0, a_reg} + {1'b0, b_reg};
  assign adc_sum   = add_sum + (DW+1)'(carry_reg);
  assign shamt     = b_reg[SHW-1:0];
  assign top_idx   = IW'(sp_reg - SPW'(1));
  assign push_idx  = IW'(sp_reg);
  assign stack_top = stack_mem[top_idx];

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    tmp_next   = tmp_reg;
    carry_next = carry_reg;
    sp_next    = sp_reg;
    err_next   = err_reg;
    op_next    = op_reg;
    beat_next  = beat_reg;
    push_ok    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_FETCH: state_next = S_OP;
      S_OP: begin
        pc_next = pc_inc;
        done    = 1'b1;
        case (data_in[3:0])
          4'h0: a_next = -a_reg;
          4'h1: a_next = a_reg & b_reg;
          4'h2: a_next = a_reg | b_reg;
          4'h3: a_next = a_reg ^ b_reg;
          4'h4: a_next = a_reg << shamt;
          4'h5: a_next = a_reg >> shamt;
          4'h6: a_next = DW'($signed(a_reg) >>> shamt);
          4'h7: {carry_next, a_next} = add_sum;
          4'h8: begin
            done       = 1'b0;
            state_next = S_EXT;
          end
          default: begin
            done       = 1'b0;
            op_next    = data_in[3:0];
            beat_next  = '0;
            state_next = S_ABEAT;
          end
        endcase
      end
      S_EXT: begin
        pc_next = pc_inc;
        done    = 1'b1;
        case (data_in[3:0])
          4'h1: begin
            if (sp_reg != '0) begin
              sp_next = sp_reg - SPW'(1);
              pc_next = stack_top;
            end else begin
              err_next = 1'b1;
            end
          end
          4'h2: begin
            done       = 1'b0;
            op_next    = 4'h8;
            beat_next  = '0;
            state_next = S_ABEAT;
          end
          4'h3: {carry_next, a_next} = adc_sum;
          4'h4: begin
            a_next = b_reg;
            b_next = a_reg;
          end
          4'h5: carry_next = 1'b0;
          default: ;
        endcase
      end
      S_ABEAT: begin
        tmp_next = off;
        if (beat_reg != BW'(NA - 1)) begin
          pc_next   = pc_inc;
          beat_next = beat_reg + BW'(1);
        end else begin
          done = 1'b1;
          case (op_reg)
            4'h9: pc_next = (a_reg == b_reg) ? pc_reg + off : pc_inc;
            4'hA: pc_next = (a_reg <= b_reg) ? pc_reg + off : pc_inc;
            4'hB: pc_next = off;
            4'h8: begin
              pc_next = off;
              if (sp_reg == SPW'(STACK_DEPTH)) begin
                err_next = 1'b1;
              end else begin
                push_ok = 1'b1;
                sp_next = sp_reg + SPW'(1);
              end
            end
            default: begin
              done       = 1'b0;
              pc_next    = pc_inc;
              state_next = S_MEM;
            end
          endcase
        end
      end
      S_MEM: begin
        done = 1'b1;
        if (op_reg == 4'hC) a_next = data_in;
        if (op_reg == 4'hD) b_next = data_in;
      end
      default: state_next = S_FETCH;
    endcase
    if (done) state_next = fast ? S_OP : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      tmp_reg   <= '0;
      carry_reg <= 1'b0;
      sp_reg    <= '0;
      err_reg   <= 1'b0;
      op_reg    <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      tmp_reg   <= tmp_next;
      carry_reg <= carry_next;
      sp_reg    <= sp_next;
      err_reg   <= err_next;
      op_reg    <= op_next;
      beat_reg  <= beat_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) stack_mem[push_idx] <= pc_inc;
  end

  assign addr_out = (state_reg == S_MEM) ? tmp_reg : pc_reg;
  assign wr_en    = rst_n && (state_reg == S_MEM) && (op_reg[3:1] == 3'b111);
  assign data_out = wr_en ? (op_reg[0] ? b_reg : a_reg) : '0;
  assign carry    = carry_reg;
  assign stk_err  = err_reg;
endmodule

// File: tb/tb_param_serial_cpu.sv
// Directed bench for param_serial_cpu (DW=4, AW=6, STACK_DEPTH=2) with a
// combinational program/data memory and a write monitor.
module tb_param_serial_cpu;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic       fast;
  logic [5:0] addr_out;
  logic [3:0] data_out;
  logic       wr_en;
  logic       carry;
  logic       stk_err;

  logic [3:0] mem [64];
  int checks = 0;
  int failures = 0;

  // write log, filled only by the monitor
  int         wr_cnt = 0;
  logic [5:0] wr_addr [64];
  logic [3:0] wr_data [64];
  logic       wr_carry [64];
  int         dout_viol = 0;
  int         err_rises = 0;
  logic [5:0] err_addr = '0;
  logic       prev_err = 1'b0;

  param_serial_cpu #(.DW(4), .AW(6), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .fast(fast),
    .addr_out(addr_out), .data_out(data_out), .wr_en(wr_en),
    .carry(carry), .stk_err(stk_err)
  );

  always #5 clk = ~clk;
  assign data_in = mem[addr_out];

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt]  = addr_out;
        wr_data[wr_cnt]  = data_out;
        wr_carry[wr_cnt] = carry;
      end
      wr_cnt = wr_cnt + 1;
    end else if (data_out != 4'h0) begin
      dout_viol = dout_viol + 1;
    end
    if (stk_err && !prev_err) begin
      err_rises = err_rises + 1;
      err_addr  = addr_out;
    end
    prev_err = stk_err;
  end

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_a;
    logic       exp_c;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
  endtask

  // Nibbles of w are placed MSB-first starting at base.
  task automatic load(input int base, input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) mem[base + i] = w[4*(n-1-i) +: 4];
  endtask

  task automatic do_reset(input logic f);
    @(negedge clk);
    rst_n = 1'b0;
    fast  = f;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int cnt;
    int rises0;
    logic found;
    logic [3:0] bop;
    logic [3:0] ba;
    logic taken;

    vecs[0] = '{4'h0, 4'h3, 4'h0, 4'hD, 1'b0};
    vecs[1] = '{4'h1, 4'hC, 4'hA, 4'h8, 1'b0};
    vecs[2] = '{4'h2, 4'hC, 4'hA, 4'hE, 1'b0};
    vecs[3] = '{4'h3, 4'hC, 4'hA, 4'h6, 1'b0};
    vecs[4] = '{4'h4, 4'h3, 4'h2, 4'hC, 1'b0};
    vecs[5] = '{4'h5, 4'hC, 4'h3, 4'h1, 1'b0};
    vecs[6] = '{4'h6, 4'h8, 4'h2, 4'hE, 1'b0};
    vecs[7] = '{4'h7, 4'h9, 4'h8, 4'h1, 1'b1};
    vecs[8] = '{4'h7, 4'h3, 4'h4, 4'h7, 1'b0};
    vecs[9] = '{4'h4, 4'h3, 4'h5, 4'h6, 1'b0};  // only B[1:0] is the shift amount

    rst_n = 1'b0;
    fast  = 1'b0;
    clear_mem();
    @(negedge clk);
    @(negedge clk);
    chk("reset_addr", addr_out, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_carry", carry, 0);
    chk("reset_stk_err", stk_err, 0);

    // ALU table: LDA 0x30, LDB 0x31, <op>, STA 0x32, JMP 0x0A
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      load(0, {24'hC30D31, vecs[v].op, 24'hE32B0A}, 13);
      mem[6'h30] = vecs[v].a;
      mem[6'h31] = vecs[v].b;
      do_reset(1'b0);
      base = wr_cnt;
      repeat (40) @(negedge clk);
      chk($sformatf("alu%0d_writes", v), wr_cnt - base, 1);
      chk($sformatf("alu%0d_addr", v), wr_addr[base], 6'h32);
      chk($sformatf("alu%0d_result", v), wr_data[base], vecs[v].exp_a);
      chk($sformatf("alu%0d_carry", v), wr_carry[base], vecs[v].exp_c);
    end

    // ADD 9+8 then ADC with B=0
    clear_mem();
    load(0, 64'hC30D317E34, 10);
    load(10, 64'hD3383E32B12, 11);
    mem[6'h30] = 4'h9; mem[6'h31] = 4'h8; mem[6'h33] = 4'h0;
    do_reset(1'b0);
    base = wr_cnt;
    repeat (60) @(negedge clk);
    chk("adc_writes", wr_cnt - base, 2);
    chk("add_result", wr_data[base], 1);
    chk("add_carry", wr_carry[base], 1);
    chk("adc_addr", wr_addr[base + 1], 6'h32);
    chk("adc_result", wr_data[base + 1], 2);
    chk("adc_carry", wr_carry[base + 1], 0);

    // single-cycle store pulse
    clear_mem();
    load(0, 64'hC30E2AB06, 9);
    mem[6'h30] = 4'h5;
    do_reset(1'b0);
    base = wr_cnt;
    cnt  = dout_viol;
    repeat (40) @(negedge clk);
    chk("sta_pulse_count", wr_cnt - base, 1);
    chk("sta_addr", wr_addr[base], 6'h2A);
    chk("sta_data", wr_data[base], 5);
    chk("sta_idle_data_out", dout_viol - cnt, 0);

    // BLE/BEQ, last operand beat at 0x0B, offset 4: taken -> 0x0F (STB 0x3E), else 0x0C (STB 0x3C)
    for (int k = 0; k < 4; k++) begin
      bop   = (k < 2) ? 4'hA : 4'h9;
      ba    = (k % 2 == 1) ? 4'h4 : 4'h3;
      taken = (ba == 4'h3);
      clear_mem();
      load(0, 64'hC30D31B09, 9);
      mem[9] = bop; mem[10] = 4'h0; mem[11] = 4'h4;
      load(12, 64'hF3CF3EB12, 9);
      mem[6'h30] = ba; mem[6'h31] = 4'h3;
      do_reset(1'b0);
      base = wr_cnt;
      repeat (60) @(negedge clk);
      chk($sformatf("br%0d_first_target", k), wr_addr[base], taken ? 6'h3E : 6'h3C);
      chk($sformatf("br%0d_writes", k), wr_cnt - base, taken ? 1 : 2);
    end

    // three nested CALLs (depth 2) then four RETs
    clear_mem();
    load(0, 64'h8218E3481, 9);
    load(9, 64'h81E35B0E, 8);
    load(6'h18, 64'h8224E3681, 9);
    load(6'h24, 64'h822C, 4);
    load(6'h2C, 64'h81, 2);
    do_reset(1'b0);
    base   = wr_cnt;
    rises0 = err_rises;
    repeat (120) @(negedge clk);
    chk("stk_err_rises", err_rises - rises0, 1);
    chk("stk_err_rise_at_third_call", err_addr, 6'h2C);
    chk("stk_writes", wr_cnt - base, 3);
    chk("stk_ret1_marker", wr_addr[base], 6'h36);
    chk("stk_ret2_marker", wr_addr[base + 1], 6'h34);
    chk("stk_underflow_marker", wr_addr[base + 2], 6'h35);
    chk("stk_err_sticky", stk_err, 1);

    // ten ADDs at 0x06..0x0F, counted in cycles spent at those addresses
    for (int f = 0; f < 2; f++) begin
      clear_mem();
      load(0, 64'hC30D31, 6);
      load(6, 64'h7777777777, 10);
      load(16, 64'hE32B13, 6);
      mem[6'h30] = 4'h5; mem[6'h31] = 4'h3;
      do_reset(f[0]);
      base = wr_cnt;
      cnt  = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (addr_out >= 6'h06 && addr_out <= 6'h0F) cnt++;
      end
      chk($sformatf("fast%0d_add_cycles", f), cnt, (f == 1) ? 10 : 20);
      chk($sformatf("fast%0d_result", f), wr_data[base], 3);
      chk($sformatf("fast%0d_carry", f), wr_carry[base], 0);
    end

    // reset asserted during the MEM cycle of a store
    clear_mem();
    load(0, 64'h81C30D317E2AB0C, 15);
    mem[6'h30] = 4'h9; mem[6'h31] = 4'h8;
    do_reset(1'b0);
    base  = wr_cnt;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (addr_out == 6'h0B) found = 1'b1;
    end
    chk("abort_reached_store", found, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_addr", addr_out, 6'h2A);
    chk("abort_no_wr_en", wr_en, 0);
    chk("abort_carry_before", carry, 1);
    chk("abort_stk_err_before", stk_err, 1);
    @(negedge clk);
    chk("abort_reset_addr", addr_out, 0);
    chk("abort_reset_carry", carry, 0);
    chk("abort_reset_stk_err", stk_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_fetch_then_op_addr", addr_out, 0);
    @(negedge clk);
    chk("abort_ext_addr", addr_out, 1);
    repeat (60) @(negedge clk);
    chk("abort_total_writes", wr_cnt - base, 1);
    chk("abort_rerun_data", wr_data[base], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
